redirect_ctrl: RTL and testbench

- Central PC-redirect and pipeline-sequencing controller for the 5-stage RV32I pipeline.
- Accepts redirect requests from DE (JAL) and EX (JALR, taken branch), plus the load-use hazard flag.
- Picks one winner per cycle by priority and drives the PC mux select, PC write enable, and IF/DE and DE/EX flush/stall.
- If instruction memory is not ready, it holds a redirect target until the fetch is accepted, so no redirect is ever lost.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/sat_counter.sv | 22 ++
 rtl/redirect_ctrl.sv | 166 ++++++++++++++++
 tb/tb_redirect_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: PC-mux select encoding, redirect FSM states and
// RV32I control-flow opcodes.
package pipe_pkg;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_JALR   = 2'b01,
    PC_BRANCH = 2'b10,
    PC_JAL    = 2'b11
  } pc_sel_t;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } redir_state_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      o_cnt <= '0;
    end else if (i_clr) begin
      o_cnt <= '0;
    end else if (i_inc && (o_cnt != {W{1'b1}})) begin
      o_cnt <= o_cnt + W'(1);
    end
  end

endmodule

// File: rtl/redirect_ctrl.sv
// PC-redirect / pipeline-sequencing controller for the 5-stage RV32I core.
// Optional statistics counters are enabled with `define REDIRECT_STATS_EN.
module redirect_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32
`ifdef REDIRECT_STATS_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            de_jal_req,
  input  logic [XLEN-1:0] de_jal_target,
  input  logic            ex_jalr_req,
  input  logic [XLEN-1:0] ex_jalr_target,
  input  logic            ex_br_taken,
  input  logic [XLEN-1:0] ex_br_target,
  input  logic            ld_use_hazard,
  input  logic            imem_ready,
  output logic [1:0]      pc_sel,
  output logic [XLEN-1:0] pc_target,
  output logic            pc_we,
  output logic            if_de_flush,
  output logic            de_ex_flush,
  output logic            if_de_stall,
  output logic            redirect_busy
`ifdef REDIRECT_STATS_EN
  ,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] hold_cnt
`endif
);

  redir_state_t    r_state;
  pc_sel_t         r_pend_sel;
  logic [XLEN-1:0] r_pend_target;

  redir_state_t    w_state_nxt;
  pc_sel_t         w_sel;
  logic [XLEN-1:0] w_target;
  logic            w_we;
  logic            w_if_de_flush;
  logic            w_de_ex_flush;
  logic            w_if_de_stall;
  logic            w_busy;
  logic            w_latch;
  logic            w_lu_stall;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= RUN;
      r_pend_sel    <= PC_PLUS4;
      r_pend_target <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_pend_sel    <= w_sel;
        r_pend_target <= w_target;
      end
    end
  end

  // Winner selection and pipeline control; a redirect that imem cannot take
  // this cycle is parked in the pending registers until the fetch is accepted.
  always_comb begin
    w_state_nxt   = r_state;
    w_sel         = PC_PLUS4;
    w_target      = '0;
    w_we          = 1'b0;
    w_if_de_flush = 1'b0;
    w_de_ex_flush = 1'b0;
    w_if_de_stall = 1'b0;
    w_busy        = 1'b0;
    w_latch       = 1'b0;
    w_lu_stall    = 1'b0;
    case (r_state)
      RUN: begin
        if (ex_jalr_req) begin
          w_sel    = PC_JALR;
          w_target = ex_jalr_target;
        end else if (ex_br_taken) begin
          w_sel    = PC_BRANCH;
          w_target = ex_br_target;
        end else if (de_jal_req) begin
          w_sel    = PC_JAL;
          w_target = de_jal_target;
        end
        if (w_sel != PC_PLUS4) begin
          w_if_de_flush = 1'b1;
          w_de_ex_flush = (w_sel != PC_JAL);
          w_we          = imem_ready;
          if (!imem_ready) begin
            w_latch     = 1'b1;
            w_state_nxt = HOLD;
          end
        end else if (ld_use_hazard) begin
          w_if_de_stall = 1'b1;
          w_de_ex_flush = 1'b1;
          w_lu_stall    = 1'b1;
        end else begin
          w_we = imem_ready;
        end
      end
      HOLD: begin
        w_sel         = r_pend_sel;
        w_target      = r_pend_target;
        w_we          = imem_ready;
        w_if_de_flush = 1'b1;
        w_de_ex_flush = (r_pend_sel != PC_JAL);
        w_busy        = 1'b1;
        if (imem_ready) begin
          w_state_nxt = RUN;
        end
      end
    endcase
  end

  // Outputs are forced quiet while reset is held.
  assign pc_sel        = RST_N ? w_sel : PC_PLUS4;
  assign pc_target     = RST_N ? w_target : '0;
  assign pc_we         = RST_N & w_we;
  assign if_de_flush   = RST_N & w_if_de_flush;
  assign de_ex_flush   = RST_N & w_de_ex_flush;
  assign if_de_stall   = RST_N & w_if_de_stall;
  assign redirect_busy = RST_N & w_busy;

`ifdef REDIRECT_STATS_EN
  logic w_redirect_acc;
  logic w_in_hold;

  assign w_redirect_acc = w_we && (w_sel != PC_PLUS4);
  assign w_in_hold      = (r_state == HOLD);

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .i_inc (w_redirect_acc),
    .i_clr (1'b0),
    .o_cnt (redirect_cnt)
  );

  sat_counter #(.W(CNT_W)) u_lu_stall_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .i_inc (w_lu_stall),
    .i_clr (1'b0),
    .o_cnt (lu_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .i_inc (w_in_hold),
    .i_clr (1'b0),
    .o_cnt (hold_cnt)
  );
`endif

  a_no_jalr_and_branch : assert property (
    @(posedge CLK) disable iff (!RST_N) !(ex_jalr_req && ex_br_taken)
  );

endmodule

// File: tb/tb_redirect_ctrl.sv
// Scoreboard bench for redirect_ctrl; per-cycle expected outputs are queued
// as stimulus is applied and popped at the falling edge.
module tb_redirect_ctrl;

  typedef struct packed {
    logic        jal;
    logic [31:0] jt;
    logic        jalr;
    logic [31:0] jrt;
    logic        br;
    logic [31:0] bt;
    logic        ld;
    logic        rdy;
  } in_t;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] tgt;
    logic        we;
    logic        ifl;
    logic        dfl;
    logic        stall;
    logic        busy;
  } out_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        de_jal_req = 1'b0;
  logic [31:0] de_jal_target = '0;
  logic        ex_jalr_req = 1'b0;
  logic [31:0] ex_jalr_target = '0;
  logic        ex_br_taken = 1'b0;
  logic [31:0] ex_br_target = '0;
  logic        ld_use_hazard = 1'b0;
  logic        imem_ready = 1'b0;
  logic [1:0]  pc_sel;
  logic [31:0] pc_target;
  logic        pc_we;
  logic        if_de_flush;
  logic        de_ex_flush;
  logic        if_de_stall;
  logic        redirect_busy;
`ifdef REDIRECT_STATS_EN
  logic [31:0] redirect_cnt;
  logic [31:0] lu_stall_cnt;
  logic [31:0] hold_cnt;
`endif

  out_t act;
  out_t exp_o;
  out_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  assign act = '{sel: pc_sel, tgt: pc_target, we: pc_we, ifl: if_de_flush,
                 dfl: de_ex_flush, stall: if_de_stall, busy: redirect_busy};

  redirect_ctrl dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .de_jal_req     (de_jal_req),
    .de_jal_target  (de_jal_target),
    .ex_jalr_req    (ex_jalr_req),
    .ex_jalr_target (ex_jalr_target),
    .ex_br_taken    (ex_br_taken),
    .ex_br_target   (ex_br_target),
    .ld_use_hazard  (ld_use_hazard),
    .imem_ready     (imem_ready),
    .pc_sel         (pc_sel),
    .pc_target      (pc_target),
    .pc_we          (pc_we),
    .if_de_flush    (if_de_flush),
    .de_ex_flush    (de_ex_flush),
    .if_de_stall    (if_de_stall),
    .redirect_busy  (redirect_busy)
`ifdef REDIRECT_STATS_EN
    ,
    .redirect_cnt   (redirect_cnt),
    .lu_stall_cnt   (lu_stall_cnt),
    .hold_cnt       (hold_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic in_t idle(input logic rdy);
    return '{jal: 1'b0, jt: 32'h0, jalr: 1'b0, jrt: 32'h0, br: 1'b0, bt: 32'h0,
             ld: 1'b0, rdy: rdy};
  endfunction

  function automatic out_t mk(input logic [1:0] sel, input logic [31:0] tgt,
                              input logic we, input logic ifl, input logic dfl,
                              input logic stall, input logic busy);
    return '{sel: sel, tgt: tgt, we: we, ifl: ifl, dfl: dfl, stall: stall, busy: busy};
  endfunction

  task automatic drive(input in_t s);
    de_jal_req     = s.jal;
    de_jal_target  = s.jt;
    ex_jalr_req    = s.jalr;
    ex_jalr_target = s.jrt;
    ex_br_taken    = s.br;
    ex_br_target   = s.bt;
    ld_use_hazard  = s.ld;
    imem_ready     = s.rdy;
  endtask

  task automatic test_reset();
    in_t  ins[3];
    out_t exps[3];
    in_t  busy_in;
    busy_in     = idle(1'b1);
    busy_in.jal = 1'b1;
    busy_in.jt  = 32'h1234;
    drive(busy_in);
    #2;
    exp_q.push_back(mk(2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_o = exp_q.pop_front();
    n_cmp++;
    if (act !== exp_o) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required %h", act, exp_o);
    end
    drive(idle(1'b1));
    #2 RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ins[i]  = idle(1'b1);
      exps[i] = mk(2'b00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      drive(ins[i]);
      exp_q.push_back(exps[i]);
      @(negedge CLK);
      exp_o = exp_q.pop_front();
      n_cmp++;
      if (act !== exp_o) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: got %h required %h", i, act, exp_o);
      end
    end
  endtask

  task automatic test_branch();
    in_t  ins[2];
    out_t exps[2];
    ins[0]    = idle(1'b1);
    ins[0].br = 1'b1;
    ins[0].bt = 32'h0000_0100;
    exps[0]   = mk(2'b10, 32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    ins[1]    = idle(1'b1);
    exps[1]   = mk(2'b00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      drive(ins[i]);
      exp_q.push_back(exps[i]);
      @(negedge CLK);
      exp_o = exp_q.pop_front();
      n_cmp++;
      if (act !== exp_o) begin
        n_err++;
        $display("FAIL branch[%0d]: got %h required %h", i, act, exp_o);
      end
    end
  endtask

  task automatic test_jalr_priority();
    in_t  ins[2];
    out_t exps[2];
    ins[0]      = idle(1'b1);
    ins[0].jalr = 1'b1;
    ins[0].jrt  = 32'h0000_0200;
    ins[0].jal  = 1'b1;
    ins[0].jt   = 32'h0000_0300;
    exps[0]     = mk(2'b01, 32'h200, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    ins[1]      = idle(1'b1);
    exps[1]     = mk(2'b00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      drive(ins[i]);
      exp_q.push_back(exps[i]);
      @(negedge CLK);
      exp_o = exp_q.pop_front();
      n_cmp++;
      if (act !== exp_o) begin
        n_err++;
        $display("FAIL jalr_priority[%0d]: got %h required %h", i, act, exp_o);
      end
    end
  endtask

  task automatic test_jal_hold();
    in_t  ins[5];
    out_t exps[5];
    ins[0]     = idle(1'b0);
    ins[0].jal = 1'b1;
    ins[0].jt  = 32'h0000_0040;
    exps[0]    = mk(2'b11, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ins[1]     = idle(1'b0);
    exps[1]    = mk(2'b11, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    ins[2]     = idle(1'b0);
    ins[2].br  = 1'b1;
    ins[2].bt  = 32'h0000_0999;
    ins[2].ld  = 1'b1;
    exps[2]    = mk(2'b11, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    ins[3]     = idle(1'b1);
    exps[3]    = mk(2'b11, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    ins[4]     = idle(1'b1);
    exps[4]    = mk(2'b00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      drive(ins[i]);
      exp_q.push_back(exps[i]);
      @(negedge CLK);
      exp_o = exp_q.pop_front();
      n_cmp++;
      if (act !== exp_o) begin
        n_err++;
        $display("FAIL jal_hold[%0d]: got %h required %h", i, act, exp_o);
      end
    end
  endtask

  task automatic test_load_use();
    in_t  ins[2];
    out_t exps[2];
    ins[0]    = idle(1'b1);
    ins[0].ld = 1'b1;
    exps[0]   = mk(2'b00, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    ins[1]    = idle(1'b1);
    ins[1].ld = 1'b1;
    ins[1].br = 1'b1;
    ins[1].bt = 32'h0000_0500;
    exps[1]   = mk(2'b10, 32'h500, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      drive(ins[i]);
      exp_q.push_back(exps[i]);
      @(negedge CLK);
      exp_o = exp_q.pop_front();
      n_cmp++;
      if (act !== exp_o) begin
        n_err++;
        $display("FAIL load_use[%0d]: got %h required %h", i, act, exp_o);
      end
    end
  endtask

  task automatic test_stats();
    @(posedge CLK); #1;
    drive(idle(1'b1));
    exp_q.push_back(mk(2'b00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge CLK);
    exp_o = exp_q.pop_front();
    n_cmp++;
    if (act !== exp_o) begin
      n_err++;
      $display("FAIL stats_idle: got %h required %h", act, exp_o);
    end
`ifdef REDIRECT_STATS_EN
    n_cmp++;
    if (redirect_cnt !== 32'd4) begin
      n_err++;
      $display("FAIL redirect_cnt: got %0d required 4", redirect_cnt);
    end
    n_cmp++;
    if (lu_stall_cnt !== 32'd1) begin
      n_err++;
      $display("FAIL lu_stall_cnt: got %0d required 1", lu_stall_cnt);
    end
    n_cmp++;
    if (hold_cnt !== 32'd3) begin
      n_err++;
      $display("FAIL hold_cnt: got %0d required 3", hold_cnt);
    end
`endif
  endtask

  task automatic test_hold_reset();
    in_t  ins[2];
    out_t exps[2];
    in_t  post[3];
    out_t post_exp[3];
    ins[0]    = idle(1'b0);
    ins[0].br = 1'b1;
    ins[0].bt = 32'h0000_0080;
    exps[0]   = mk(2'b10, 32'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    ins[1]    = idle(1'b0);
    exps[1]   = mk(2'b10, 32'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      drive(ins[i]);
      exp_q.push_back(exps[i]);
      @(negedge CLK);
      exp_o = exp_q.pop_front();
      n_cmp++;
      if (act !== exp_o) begin
        n_err++;
        $display("FAIL hold_entry[%0d]: got %h required %h", i, act, exp_o);
      end
    end
    #1 RST_N = 1'b0;
    #1;
    exp_q.push_back(mk(2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_o = exp_q.pop_front();
    n_cmp++;
    if (act !== exp_o) begin
      n_err++;
      $display("FAIL hold_reset_outputs: got %h required %h", act, exp_o);
    end
`ifdef REDIRECT_STATS_EN
    n_cmp++;
    if ({redirect_cnt, lu_stall_cnt, hold_cnt} !== 96'h0) begin
      n_err++;
      $display("FAIL hold_reset_counters: got %0d/%0d/%0d required 0/0/0",
               redirect_cnt, lu_stall_cnt, hold_cnt);
    end
`endif
    #1 RST_N = 1'b1;
    post[0]      = idle(1'b1);
    post_exp[0]  = mk(2'b00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    post[1]      = idle(1'b1);
    post[1].jal  = 1'b1;
    post[1].jt   = 32'hFFFF_FFFC;
    post_exp[1]  = mk(2'b11, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    post[2]      = idle(1'b0);
    post_exp[2]  = mk(2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      drive(post[i]);
      exp_q.push_back(post_exp[i]);
      @(negedge CLK);
      exp_o = exp_q.pop_front();
      n_cmp++;
      if (act !== exp_o) begin
        n_err++;
        $display("FAIL after_hold_reset[%0d]: got %h required %h", i, act, exp_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jalr_priority();
    test_jal_hold();
    test_load_use();
    test_stats();
    test_hold_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
